shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned multiplier for the multicycle processor's ALU. It forms a 2W-bit product using the radix-2 shift-and-add method: one W-bit ripple addition per cycle, W cycles per multiply. It sits beside the ALU's W-bit adder. It supplies that adder's operands (partial-product high half, multiplicand, carry-in 0) and consumes its sum and carry-out every cycle. It uses a start/done handshake so the control FSM can stall the multiply state.

## Interface
- W, default 32: operand width; product is 2W bits; W ≥ 2.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only when not busy.
- a  input  W  multiplicand; captured on the accepted start edge.
- b  input  W  multiplier; captured on the accepted start edge.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse: product valid.
- product  output  2W  {hi, lo} result; held until the next accepted start.

## Operation
- Reset values (rst high at a rising edge): state = IDLE; busy = 0; done = 0; product = 0; internal mcand = 0; count = 0.
- Registers:
  - mcand[W-1:0]
  - acc[2W-1:0], which drives product directly
  - count, ceil(log2(W+1)) bits
  - state
- States: IDLE, RUN, DONE.
- IDLE: if start = 1, then mcand ← a, acc ← {W zeros, b}, count ← 0, and go to RUN. Otherwise hold.
- RUN, each cycle:
  - {c, s} = acc[2W-1:W] + (acc[0] ? mcand : 0), a W-bit add with carry-in 0.
  - acc ← {c, s, acc[W-1:1]}: logical right shift by one, with carry-out into bit 2W-1.
  - count ← count + 1.
  - When count = W-1 on this edge, go to DONE.
- DONE: done = 1 for this single cycle; product = a×b (unsigned, exact, no truncation).
  - If start = 1 in DONE, it is accepted as in IDLE, so back-to-back operation is allowed; go to RUN.
  - Otherwise go to IDLE.
- busy = 1 exactly in RUN; done = 1 exactly in DONE. busy and done are never both 1.
- start while in RUN is ignored. a and b changes after capture have no effect.
- In IDLE, product holds the last result. It changes only when a start is accepted; at that point it shows {0, b} and then intermediate values.
- Arithmetic rules:
  - Unsigned only. The product never overflows 2W bits.
  - The carry-out of every addition is retained, never dropped.
- Reset mid-RUN or in DONE: all outputs return to reset values on that edge and the partial result is discarded.
- rst has priority over start on the same edge.

## Timing
- Start accepted at edge E0. Adds happen at edges E1..EW, and state = DONE after edge EW.
- done and valid product are visible in the cycle between EW and EW+1.
- Latency: W+1 cycles from the start edge to done sampled high (33 for W = 32).
- Throughput with back-to-back starts (start held high): one result every W+1 cycles.
- Outputs are registered. No combinational path exists from any input to any output.
- Critical path: one W-bit ripple add plus a 2:1 mux. No multi-cycle paths.

## Test plan
- Basic, W=32: a=3, b=5, start 1 cycle -> busy high for 32 cycles; done pulses exactly once on cycle 33; product = 0x0000_0000_0000_000F; busy = 0 on the done cycle.
- Maximum operands: a = b = 0xFFFF_FFFF -> product = 0xFFFF_FFFE_0000_0001. This checks that the carry-out is retained in every iteration.
- Zero and identity:
  - a=0, b=0xDEAD_BEEF -> product 0.
  - a=0x1234_5678, b=1 -> product 0x0000_0000_1234_5678.
  - After done, product stays stable across 10 idle cycles with random a/b.
- Ignore during busy: a=7, b=9 started; at cycle 10, pulse start with a=2, b=2 -> product = 63, and only one done pulse occurs.
- Reset mid-operation: start a=0xFFFF, b=0xFFFF; assert rst at cycle 15 -> next cycle busy=0, done=0, product=0. A new start a=6, b=7 -> 42 after 33 cycles.
- Back-to-back: hold start high with a=10, b=20, then a=0x8000_0000, b=2 presented on the first done cycle -> done pulses at cycles 33 and 66; products are 200 then 0x0000_0001_0000_0000.

Source files
------------

// File: rtl/shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_multiplier
// Purpose  : Sequential unsigned radix-2 shift-and-add multiplier. Performs
//            one W-bit add per cycle and forms the exact 2W-bit product of
//            a x b in W cycles, with a start/done handshake.
// Ports    : clk      - rising-edge clock
//            rst      - synchronous active-high reset
//            start    - multiply request, sampled when not busy
//            a, b     - multiplicand / multiplier, captured on accepted start
//            busy     - high while the multiply iterates
//            done     - one-cycle pulse, product valid
//            product  - {hi, lo} result, held until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
    parameter int W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   product
);

    localparam int            CW       = $clog2(W + 1);
    localparam logic [CW-1:0] c_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] c_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state_q;
    state_t             w_state_d;
    logic [W-1:0]       r_mcand_q;
    logic [W-1:0]       w_mcand_d;
    logic [2*W-1:0]     r_acc_q;
    logic [2*W-1:0]     w_acc_d;
    logic [CW-1:0]      r_count_q;
    logic [CW-1:0]      w_count_d;
    logic               r_busy_q;
    logic               w_busy_d;
    logic               r_done_q;
    logic               w_done_d;

    logic [W-1:0]       w_addend;
    logic [W:0]         w_sum;      // {carry-out, sum} of the shared W-bit adder

    always_comb begin
        w_state_d = r_state_q;
        w_mcand_d = r_mcand_q;
        w_acc_d   = r_acc_q;
        w_count_d = r_count_q;

        // Adder operands: high half of the partial product plus the
        // multiplicand when the current multiplier LSB is set.
        w_addend  = r_acc_q[0] ? r_mcand_q : '0;
        w_sum     = {1'b0, r_acc_q[2*W-1:W]} + {1'b0, w_addend};

        case (r_state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_mcand_d = a;
                    w_acc_d   = {{W{1'b0}}, b};
                    w_count_d = '0;
                    w_state_d = ST_RUN;
                end else if (r_state_q == ST_DONE) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Carry-out lands in the top bit so no product bit is lost;
                // the consumed multiplier bit falls off the bottom.
                w_acc_d   = {w_sum, r_acc_q[W-1:1]};
                w_count_d = r_count_q + c_ONE;
                if (r_count_q == c_LAST) begin
                    w_state_d = ST_DONE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase

        w_busy_d = (w_state_d == ST_RUN);
        w_done_d = (w_state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
            r_mcand_q <= '0;
            r_acc_q   <= '0;
            r_count_q <= '0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_mcand_q <= w_mcand_d;
            r_acc_q   <= w_acc_d;
            r_count_q <= w_count_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
        end
    end

    assign busy    = r_busy_q;
    assign done    = r_done_q;
    assign product = r_acc_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_multiplier
// Purpose  : Directed self-checking bench for shift_add_multiplier (W = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_add_multiplier;

    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int checks;
    int failures;

    shift_add_multiplier #(.W(W)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a start for exactly one edge (E0); returns #1 after E0.
    task automatic pulse_start(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        step();
        start = 1'b0;
    endtask

    // Advance until done is seen, bounded; edges counts edges after E0.
    task automatic wait_done(output int edges, output bit ok);
        edges = 0;
        ok    = 1'b0;
        while (edges < 100) begin
            step();
            edges++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        step();
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
        checks++;
        if (product !== 64'h0) begin failures++; $display("FAIL reset_product actual=%h required=0", product); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int busy_cycles;
        int edges;
        bit got;
        pulse_start(32'd3, 32'd5);
        checks++;
        if (product !== 64'h5) begin failures++; $display("FAIL basic_load_product actual=%h required=%h", product, 64'h5); end
        busy_cycles = busy ? 1 : 0;
        edges = 0;
        got = 1'b0;
        while (edges < 100) begin
            step();
            edges++;
            if (done) begin got = 1'b1; break; end
            if (busy) busy_cycles++;
        end
        checks++;
        if (!got || edges + 1 != 33) begin failures++; $display("FAIL basic_latency actual=%0d required=33", edges + 1); end
        checks++;
        if (busy_cycles != 32) begin failures++; $display("FAIL basic_busy_cycles actual=%0d required=32", busy_cycles); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_on_done actual=%b required=0", busy); end
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin failures++; $display("FAIL basic_product actual=%h required=%h", product, 64'hF); end
        step();
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_done_one_cycle actual=%b required=0", done); end
    endtask

    task automatic test_max();
        int edges;
        bit ok;
        pulse_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, ok);
        checks++;
        if (!ok || product !== 64'hFFFF_FFFE_0000_0001) begin
            failures++;
            $display("FAIL max_product actual=%h required=%h", product, 64'hFFFF_FFFE_0000_0001);
        end
    endtask

    task automatic test_zero_identity();
        int edges;
        bit ok;
        logic [2*W-1:0] held;
        bit stable;
        pulse_start(32'h0, 32'hDEAD_BEEF);
        wait_done(edges, ok);
        checks++;
        if (!ok || product !== 64'h0) begin failures++; $display("FAIL zero_product actual=%h required=0", product); end
        pulse_start(32'h1234_5678, 32'h1);
        wait_done(edges, ok);
        checks++;
        if (!ok || product !== 64'h0000_0000_1234_5678) begin
            failures++;
            $display("FAIL identity_product actual=%h required=%h", product, 64'h1234_5678);
        end
        held = 64'h0000_0000_1234_5678;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = $urandom;
            step();
            if (product !== held || done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin failures++; $display("FAIL idle_hold actual=%h required=%h", product, held); end
    endtask

    task automatic test_ignore_busy();
        int pulses;
        logic [2*W-1:0] result;
        pulse_start(32'd7, 32'd9);
        pulses = 0;
        result = '0;
        for (int c = 2; c <= 45; c++) begin
            if (c == 10) begin
                start = 1'b1;
                a = 32'd2;
                b = 32'd2;
            end else begin
                start = 1'b0;
            end
            step();
            if (done) begin
                pulses++;
                result = product;
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL ignore_done_pulses actual=%0d required=1", pulses); end
        checks++;
        if (result !== 64'd63) begin failures++; $display("FAIL ignore_product actual=%h required=%h", result, 64'd63); end
    endtask

    task automatic test_reset_mid();
        int edges;
        bit ok;
        pulse_start(32'hFFFF, 32'hFFFF);
        for (int i = 0; i < 14; i++) step();
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
            failures++;
            $display("FAIL midreset_outputs actual=%b/%b/%h required=0/0/0", busy, done, product);
        end
        rst = 1'b0;
        pulse_start(32'd6, 32'd7);
        wait_done(edges, ok);
        checks++;
        if (!ok || edges + 1 != 33) begin failures++; $display("FAIL midreset_latency actual=%0d required=33", edges + 1); end
        checks++;
        if (product !== 64'd42) begin failures++; $display("FAIL midreset_product actual=%h required=%h", product, 64'd42); end
    endtask

    task automatic test_back_to_back();
        int edges;
        bit ok;
        @(negedge clk);
        start = 1'b1;
        a = 32'd10;
        b = 32'd20;
        step();
        wait_done(edges, ok);
        checks++;
        if (!ok || edges + 1 != 33) begin failures++; $display("FAIL b2b_first_latency actual=%0d required=33", edges + 1); end
        checks++;
        if (product !== 64'd200) begin failures++; $display("FAIL b2b_first_product actual=%h required=%h", product, 64'd200); end
        a = 32'h8000_0000;
        b = 32'd2;
        wait_done(edges, ok);
        start = 1'b0;
        checks++;
        if (!ok || edges != 33) begin failures++; $display("FAIL b2b_second_spacing actual=%0d required=33", edges); end
        checks++;
        if (product !== 64'h0000_0001_0000_0000) begin
            failures++;
            $display("FAIL b2b_second_product actual=%h required=%h", product, 64'h1_0000_0000);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_return_idle actual=%b/%b required=0/0", busy, done); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_max();
        test_zero_identity();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
